// File: rtl/cordic_job_scheduler_if.sv
// Requester, response and CORDIC-core signals of the job scheduler.
// slave = scheduler side; master = requesters plus core.
interface cordic_job_scheduler_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_cos;
  logic [31:0] req_angle0;
  logic [31:0] req_angle1;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        core_start;
  logic        core_cos;
  logic [31:0] core_angle;
  logic        core_done;
  logic [31:0] core_result;

  modport slave (
    input  req_valid, req_cos, req_angle0, req_angle1, core_done, core_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, core_start, core_cos, core_angle
  );

  modport master (
    output req_valid, req_cos, req_angle0, req_angle1, core_done, core_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, core_start, core_cos, core_angle
  );
endinterface

// File: rtl/cordic_job_scheduler.sv
// Round-robin two-port front end for the shared CORDIC core: issue, watchdog-bounded
// wait, and a one-cycle response to the requester that owns the job.
module cordic_job_scheduler #(
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_job_scheduler_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          owner_q;
  logic          last_q;
  logic          core_start_q;
  logic          core_cos_q;
  logic [31:0]   core_angle_q;
  logic [1:0]    rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;
  logic          busy_q;

  logic          grant_d;
  logic [1:0]    ready_d;
  logic          hs_d;

  // On contention the requester that did not win last time gets the core.
  always_comb begin
    grant_d = bus.req_valid[1];
    if (bus.req_valid == 2'b11) grant_d = ~last_q;
    ready_d = 2'b00;
    if (state_q == IDLE && |bus.req_valid) ready_d = grant_d ? 2'b10 : 2'b01;
    hs_d = |(bus.req_valid & ready_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      core_start_q <= 1'b0;
      core_cos_q   <= 1'b0;
      core_angle_q <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs_d) begin
            core_angle_q <= grant_d ? bus.req_angle1 : bus.req_angle0;
            core_cos_q   <= bus.req_cos[grant_d];
            owner_q      <= grant_d;
            last_q       <= grant_d;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
          cnt_q        <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          // A done arriving on the last watchdog cycle still counts as success.
          if (bus.core_done) begin
            rsp_data_q  <= bus.core_result;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          rsp_valid_q <= 2'b00;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_d;
  assign bus.core_start = core_start_q;
  assign bus.core_cos   = core_cos_q;
  assign bus.core_angle = core_angle_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_cordic_job_scheduler.sv
// Directed bench for cordic_job_scheduler (TIMEOUT=8): arbitration, timing, watchdog, reset.
module tb_cordic_job_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   nchk = 0;

  cordic_job_scheduler_if bus ();

  cordic_job_scheduler #(.TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one job; done is pulsed dly cycles after core_start. Returns in the IDLE cycle after RESP.
  task automatic job(input logic [1:0] vld, input logic [1:0] exp_g, input logic [31:0] ang,
                     input logic cs, input int dly, input logic [31:0] res);
    bus.req_valid = vld;
    #1;
    chk("ready", 32'(bus.req_ready), 32'(exp_g));
    @(negedge clk);
    chk("start", 32'(bus.core_start), 32'd1);
    chk("angle", bus.core_angle, ang);
    chk("cos", 32'(bus.core_cos), 32'(cs));
    chk("busy_hi", 32'(bus.busy), 32'd1);
    chk("ready_busy", 32'(bus.req_ready), 32'd0);
    for (int i = 1; i < dly; i++) begin
      @(negedge clk);
      chk("start_lo", 32'(bus.core_start), 32'd0);
      chk("no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(negedge clk);
    bus.core_done = 1'b1;
    bus.core_result = res;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_g));
    chk("rsp_data", bus.rsp_data, res);
    chk("rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    chk("rsp_off", 32'(bus.rsp_valid), 32'd0);
    chk("busy_lo", 32'(bus.busy), 32'd0);
    chk("data_hold", bus.rsp_data, res);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_valid = 2'b00; bus.req_cos = 2'b00;
    bus.req_angle0 = '0; bus.req_angle1 = '0;
    bus.core_done = 1'b0; bus.core_result = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_start", 32'(bus.core_start), 32'd0);
    chk("rst_cos", 32'(bus.core_cos), 32'd0);
    chk("rst_angle", bus.core_angle, 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: both held, grants 0,1,0,1 starting from requester 0.
    bus.req_angle0 = 32'h11111111; bus.req_angle1 = 32'h22222222; bus.req_cos = 2'b10;
    job(2'b11, 2'b01, 32'h11111111, 1'b0, 1, 32'hF0000001);
    job(2'b11, 2'b10, 32'h22222222, 1'b1, 2, 32'hF0000002);
    job(2'b11, 2'b01, 32'h11111111, 1'b0, 3, 32'hF0000003);
    job(2'b11, 2'b10, 32'h22222222, 1'b1, 1, 32'hF0000004);
    bus.req_valid = 2'b00;

    // Single job, done 3 cycles after start.
    bus.req_angle0 = 32'h3243F6A8; bus.req_cos = 2'b01;
    job(2'b01, 2'b01, 32'h3243F6A8, 1'b1, 3, 32'hAAAA5555);
    bus.req_valid = 2'b00;

    // Watchdog: no done, response at T+10 with error.
    bus.req_angle1 = 32'h0BADF00D; bus.req_cos = 2'b10; bus.req_valid = 2'b10;
    #1 chk("to_ready", 32'(bus.req_ready), 32'd2);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("to_start", 32'(bus.core_start), 32'd1);
    for (int n = 2; n <= 9; n++) @(negedge clk);
    chk("to_early", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("to_valid", 32'(bus.rsp_valid), 32'd2);
    chk("to_err", 32'(bus.rsp_err), 32'd1);
    chk("to_data", bus.rsp_data, 32'd0);
    @(negedge clk);
    chk("to_busy", 32'(bus.busy), 32'd0);
    chk("to_off", 32'(bus.rsp_valid), 32'd0);
    chk("to_err_hold", 32'(bus.rsp_err), 32'd1);

    // Done exactly on the last watchdog cycle wins.
    job(2'b10, 2'b10, 32'h0BADF00D, 1'b1, 8, 32'h5A5A0001);
    bus.req_valid = 2'b00;

    // Stray done in IDLE.
    bus.core_done = 1'b1; bus.core_result = 32'hDEADBEEF;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("stray_idle_busy", 32'(bus.busy), 32'd0);
    chk("stray_idle_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("stray_idle_rsp2", 32'(bus.rsp_valid), 32'd0);
    chk("stray_idle_data", bus.rsp_data, 32'h5A5A0001);

    // Stray done in ISSUE, real done later.
    bus.req_angle0 = 32'h01234567; bus.req_cos = 2'b00; bus.req_valid = 2'b01;
    #1 chk("st_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.core_done = 1'b1; bus.core_result = 32'hDEADBEEF;
    chk("st_start", 32'(bus.core_start), 32'd1);
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("st_rsp2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("st_rsp3", 32'(bus.rsp_valid), 32'd0);
    chk("st_busy3", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.core_done = 1'b1; bus.core_result = 32'h13579BDF;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("st_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("st_rsp_data", bus.rsp_data, 32'h13579BDF);
    @(negedge clk);

    // Reset during WAIT drops the job.
    bus.req_angle1 = 32'h7FFFFFFF; bus.req_cos = 2'b10; bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = 2'b00;
    @(negedge clk); @(negedge clk);
    chk("mr_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_start", 32'(bus.core_start), 32'd0);
    chk("mr_cos", 32'(bus.core_cos), 32'd0);
    chk("mr_angle", bus.core_angle, 32'd0);
    chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mr_rsp_data", bus.rsp_data, 32'd0);
    chk("mr_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("mr_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.core_done = 1'b1; bus.core_result = 32'h11112222;
    @(negedge clk);
    bus.core_done = 1'b0;
    chk("mr_late_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("mr_late_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("mr_late_rsp2", 32'(bus.rsp_valid), 32'd0);
    chk("mr_late_data", bus.rsp_data, 32'd0);
    bus.req_angle0 = 32'h00000042; bus.req_valid = 2'b11;
    #1 chk("mr_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 2'b00;
    chk("mr_start2", 32'(bus.core_start), 32'd1);
    chk("mr_angle2", bus.core_angle, 32'h00000042);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
